// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and defaults for the hazard scoreboard: forward-select
// encoding and the default load-use latency.
package plcpu_hazard_pkg;

  localparam int unsigned LOAD_LAT_DEF = 1;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-hazard-unit bundle: ID/EX/MEM/WB observation inputs and the
// stall / forward-select outputs.
interface hazard_scoreboard_if
  import plcpu_hazard_pkg::*;
#(
  parameter int unsigned RIDX_W = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [RIDX_W-1:0] id_rs1;
  logic [RIDX_W-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [RIDX_W-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_long;
  logic              flush;
  logic [RIDX_W-1:0] ex_rs1;
  logic [RIDX_W-1:0] ex_rs2;
  logic [RIDX_W-1:0] mem_rs2;
  logic [RIDX_W-1:0] mem_rd;
  logic              mem_regwrite;
  logic              mem_memwrite;
  logic [RIDX_W-1:0] wb_rd;
  logic              wb_regwrite;
  logic              long_done;
  logic [RIDX_W-1:0] long_rd;
  logic              stall;
  fwd_sel_t          bus_a_fw;
  fwd_sel_t          bus_b_fw;
  logic              di_src;
  logic              long_busy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite,
           id_memread, id_long, flush, ex_rs1, ex_rs2, mem_rs2, mem_rd,
           mem_regwrite, mem_memwrite, wb_rd, wb_regwrite, long_done, long_rd,
    input  stall, bus_a_fw, bus_b_fw, di_src, long_busy, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite,
           id_memread, id_long, flush, ex_rs1, ex_rs2, mem_rs2, mem_rd,
           mem_regwrite, mem_memwrite, wb_rd, wb_regwrite, long_done, long_rd,
    output stall, bus_a_fw, bus_b_fw, di_src, long_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_fwd_sel.sv
// EX operand forward select: MEM result has priority over WB; x0 never forwards.
module hdu_fwd_sel
  import plcpu_hazard_pkg::*;
#(
  parameter int unsigned RIDX_W = 5
) (
  input  logic [RIDX_W-1:0] ex_rs,
  input  logic [RIDX_W-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic              wb_regwrite,
  output fwd_sel_t          sel_c
);
  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs);
    wb_hit  = wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs);
    sel_c   = FWD_RF;
    if (mem_hit) begin
      sel_c = FWD_MEM;
    end else if (wb_hit) begin
      sel_c = FWD_WB;
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// ID/EX hazard unit with a per-register scoreboard for load-use latency and a
// single variable-latency unit, plus EX/MEM forward selects and a stall counter.
module hazard_scoreboard
  import plcpu_hazard_pkg::*;
#(
  parameter int unsigned NREG     = 32,
  parameter int unsigned RIDX_W   = 5,
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
  parameter int unsigned LAT_W    = 2,
  parameter int unsigned CNT_W    = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave hz
);
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  is_long;
  logic             stall_c;
  logic             issue_c;
  logic             long_busy_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Reset forces the stall low so the front end can drain during reset.
  assign stall_c = ~rst & hz.id_valid &
                   ((hz.id_use_rs1 & busy[hz.id_rs1]) |
                    (hz.id_use_rs2 & busy[hz.id_rs2]) |
                    (hz.id_regwrite & is_long[hz.id_rd]) |
                    (hz.id_long & long_busy_q));

  assign issue_c = hz.id_valid & ~stall_c & ~hz.flush & hz.id_regwrite &
                   (hz.id_rd != '0);

  assign busy[0]    = 1'b0;
  assign is_long[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_ent
    logic             busy_q;
    logic             long_q;
    logic [LAT_W-1:0] cnt_q;
    logic             rd_hit;
    logic             done_hit;

    assign rd_hit   = (hz.id_rd == RIDX_W'(i));
    assign done_hit = hz.long_done && (hz.long_rd == RIDX_W'(i));

    // A fresh issue to this index overrides any countdown in progress.
    always_ff @(posedge clk) begin
      if (rst) begin
        busy_q <= 1'b0;
        long_q <= 1'b0;
        cnt_q  <= '0;
      end else if (issue_c && rd_hit && (hz.id_long || hz.id_memread)) begin
        busy_q <= 1'b1;
        long_q <= hz.id_long;
        cnt_q  <= hz.id_long ? '0 : LAT_W'(LOAD_LAT);
      end else if (long_q) begin
        if (done_hit) begin
          busy_q <= 1'b0;
          long_q <= 1'b0;
        end
      end else if (busy_q) begin
        cnt_q <= cnt_q - LAT_W'(1);
        if (cnt_q <= LAT_W'(1)) begin
          busy_q <= 1'b0;
        end
      end
    end

    assign busy[i]    = busy_q;
    assign is_long[i] = long_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      long_busy_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (issue_c && hz.id_long) begin
        long_busy_q <= 1'b1;
      end else if (hz.long_done) begin
        long_busy_q <= 1'b0;
      end
      if (stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  hdu_fwd_sel #(.RIDX_W(RIDX_W)) u_fwd_a (
    .ex_rs        (hz.ex_rs1),
    .mem_rd       (hz.mem_rd),
    .mem_regwrite (hz.mem_regwrite),
    .wb_rd        (hz.wb_rd),
    .wb_regwrite  (hz.wb_regwrite),
    .sel_c        (hz.bus_a_fw)
  );

  hdu_fwd_sel #(.RIDX_W(RIDX_W)) u_fwd_b (
    .ex_rs        (hz.ex_rs2),
    .mem_rd       (hz.mem_rd),
    .mem_regwrite (hz.mem_regwrite),
    .wb_rd        (hz.wb_rd),
    .wb_regwrite  (hz.wb_regwrite),
    .sel_c        (hz.bus_b_fw)
  );

  assign hz.di_src    = hz.wb_regwrite & (hz.wb_rd != '0) & (hz.wb_rd == hz.mem_rs2) &
                        hz.mem_memwrite;
  assign hz.stall     = stall_c;
  assign hz.long_busy = long_busy_q;
  assign hz.stall_cnt = stall_cnt_q;
endmodule
